// File: rtl/jpeg_idct_pkg.sv
// Shared types and helpers for the IDCT transpose-buffer controller.
// Bank life cycle: FREE -> FULL (last write) -> READING (first read) -> FREE (64th read).
package jpeg_idct_pkg;

  localparam int BLK_SAMPLES = 64;
  localparam int IDX_W       = 6;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FULL    = 2'd1,
    BANK_READING = 2'd2
  } bank_state_e;

  // Row-major index {row,col} becomes {col,row} so a bank drains column by column.
  function automatic logic [IDX_W-1:0] xpose_addr(input logic [IDX_W-1:0] idx,
                                                  input logic            transpose);
    return transpose ? {idx[2:0], idx[5:3]} : idx;
  endfunction

endpackage

// File: rtl/jpeg_idct_xpose_fifo2.sv
// Two-entry register FIFO; head is always slot0, count exposes occupancy.
module jpeg_idct_xpose_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = slot0;
  assign valid   = (count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; the new word lands behind any survivor.
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jpeg_idct_xpose_ctrl.sv
// Ping-pong controller for the IDCT transpose buffer: fills one 64-entry bank row-major
// while the other drains column-major through a 2-entry output FIFO.
module jpeg_idct_xpose_ctrl
  import jpeg_idct_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit TRANSPOSE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inport_valid_i,
  input  logic [DATA_W-1:0] inport_data_i,
  output logic              inport_ready_o,
  output logic              outport_valid_o,
  output logic [DATA_W-1:0] outport_data_o,
  output logic              outport_last_o,
  input  logic              outport_ready_i,
  output logic              ram_wr_o,
  output logic [6:0]        ram_waddr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [6:0]        ram_raddr_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o
);

  // Handshakes: a word transfers on a rising clk_i edge where valid and ready are both high;
  // valid never depends on ready, and ready never depends on valid.
  bank_state_e          bank_state     [2];
  bank_state_e          bank_state_nxt [2];
  logic                 wr_bank;
  logic [IDX_W-1:0]     wr_idx;
  logic                 rd_bank;
  logic [IDX_W-1:0]     rd_idx;
  logic                 inflight;
  logic                 inflight_last;
  logic [6:0]           raddr_q;
  logic                 wr_fire;
  logic                 wr_last;
  logic                 rd_avail;
  logic                 rd_issue;
  logic                 rd_last;
  logic                 pop;
  logic [2:0]           occupancy;
  logic [1:0]           fifo_count;
  logic                 fifo_valid;
  logic [DATA_W:0]      fifo_head;

  assign inport_ready_o = (bank_state[wr_bank] == BANK_FREE);
  assign wr_fire        = inport_valid_i && inport_ready_o;
  assign wr_last        = (wr_idx == IDX_W'(BLK_SAMPLES - 1));
  assign ram_wr_o       = wr_fire;
  assign ram_waddr_o    = {wr_bank, wr_idx};
  assign ram_wdata_o    = inport_data_i;

  // A read is only issued if its data is guaranteed a FIFO slot on return.
  assign pop       = outport_valid_o && outport_ready_i;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign rd_avail  = (bank_state[rd_bank] == BANK_FULL) || (bank_state[rd_bank] == BANK_READING);
  assign rd_issue  = rd_avail && (occupancy < 3'd2);
  assign rd_last   = (rd_idx == IDX_W'(BLK_SAMPLES - 1));

  assign ram_raddr_o = rd_issue ? {rd_bank, xpose_addr(rd_idx, TRANSPOSE)} : raddr_q;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_state_nxt[b] = bank_state[b];
      if (wr_fire && wr_last && (wr_bank == 1'(b))) bank_state_nxt[b] = BANK_FULL;
      if (rd_issue && (rd_bank == 1'(b)))
        bank_state_nxt[b] = rd_last ? BANK_FREE : BANK_READING;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_state[0] <= BANK_FREE;
      bank_state[1] <= BANK_FREE;
      wr_bank       <= 1'b0;
      wr_idx        <= '0;
      rd_bank       <= 1'b0;
      rd_idx        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      raddr_q       <= '0;
    end else begin
      bank_state[0] <= bank_state_nxt[0];
      bank_state[1] <= bank_state_nxt[1];
      if (wr_fire) begin
        wr_idx <= wr_idx + IDX_W'(1);
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (rd_issue) begin
        rd_idx <= rd_idx + IDX_W'(1);
        if (rd_last) rd_bank <= ~rd_bank;
      end
      inflight      <= rd_issue;
      inflight_last <= rd_issue && rd_last;
      raddr_q       <= ram_raddr_o;
    end
  end

  jpeg_idct_xpose_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (inflight),
    .push_data ({inflight_last, ram_rdata_i}),
    .pop       (pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign outport_valid_o = fifo_valid;
  assign outport_data_o  = fifo_head[DATA_W-1:0];
  assign outport_last_o  = fifo_valid && fifo_head[DATA_W];

  assign busy_o = (bank_state[0] != BANK_FREE) || (bank_state[1] != BANK_FREE) ||
                  (fifo_count != 2'd0);

endmodule

// File: tb/tb_jpeg_idct_xpose_ctrl.sv
// Bench for jpeg_idct_xpose_ctrl: a transposing and a bypass instance share one input stream;
// each has its own RAM model and expected queue built from 8x8 block arithmetic.
module tb_jpeg_idct_xpose_ctrl;

  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         drv_valid;
  logic [W-1:0] drv_data;
  logic         ready_force;
  logic         rnd_mode;
  logic         rnd_bit;
  logic         out_ready;
  assign out_ready = rnd_mode ? rnd_bit : ready_force;

  int total = 0;
  int bad   = 0;

  // transposing instance (xp) and bypass instance (st)
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_last, a_wr, a_busy;
  logic [W-1:0] a_out_data, a_wdata, a_rdata;
  logic [6:0]   a_waddr, a_raddr;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_last, b_wr, b_busy;
  logic [W-1:0] b_out_data, b_wdata, b_rdata;
  logic [6:0]   b_waddr, b_raddr;

  assign a_in_valid = drv_valid && b_in_ready;
  assign b_in_valid = drv_valid && a_in_ready;

  jpeg_idct_xpose_ctrl #(.DATA_W(W), .TRANSPOSE(1'b1)) u_dut_xp (
    .clk_i(clk), .rst_i(rst),
    .inport_valid_i(a_in_valid), .inport_data_i(drv_data), .inport_ready_o(a_in_ready),
    .outport_valid_o(a_out_valid), .outport_data_o(a_out_data), .outport_last_o(a_out_last),
    .outport_ready_i(out_ready),
    .ram_wr_o(a_wr), .ram_waddr_o(a_waddr), .ram_wdata_o(a_wdata),
    .ram_raddr_o(a_raddr), .ram_rdata_i(a_rdata), .busy_o(a_busy)
  );

  jpeg_idct_xpose_ctrl #(.DATA_W(W), .TRANSPOSE(1'b0)) u_dut_st (
    .clk_i(clk), .rst_i(rst),
    .inport_valid_i(b_in_valid), .inport_data_i(drv_data), .inport_ready_o(b_in_ready),
    .outport_valid_o(b_out_valid), .outport_data_o(b_out_data), .outport_last_o(b_out_last),
    .outport_ready_i(out_ready),
    .ram_wr_o(b_wr), .ram_waddr_o(b_waddr), .ram_wdata_o(b_wdata),
    .ram_raddr_o(b_raddr), .ram_rdata_i(b_rdata), .busy_o(b_busy)
  );

  logic [W-1:0] a_mem [128];
  logic [W-1:0] b_mem [128];
  always @(posedge clk) begin
    if (a_wr) a_mem[a_waddr] <= a_wdata;
    if (b_wr) b_mem[b_waddr] <= b_wdata;
    a_rdata <= a_mem[a_raddr];
    b_rdata <= b_mem[b_raddr];
  end

  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  // reference model: 8x8 block, emitted by columns (xp) or by rows (st)
  logic [W:0]   exp_xp[$];
  logic [W:0]   exp_st[$];
  logic [W-1:0] blk [64];
  int           nsamp = 0;
  int           last_acc_cyc = 0;

  task automatic model_accept(input logic [W-1:0] d);
    blk[nsamp] = d;
    nsamp++;
    if (nsamp == 64) begin
      for (int col = 0; col < 8; col++)
        for (int row = 0; row < 8; row++)
          exp_xp.push_back({(col == 7 && row == 7), blk[row*8 + col]});
      for (int i = 0; i < 64; i++)
        exp_st.push_back({(i == 63), blk[i]});
      nsamp = 0;
    end
  endtask

  task automatic report_and_finish();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // driver tasks
  task automatic send(input logic [W-1:0] d);
    logic acc;
    int   guard;
    drv_valid = 1'b1;
    drv_data  = d;
    acc       = 1'b0;
    guard     = 0;
    while (!acc) begin
      @(negedge clk);
      acc = a_in_ready && b_in_ready;
      last_acc_cyc = cyc;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 1000) begin
        total++;
        bad++;
        $display("FAIL send_timeout got=stalled required=accept");
        report_and_finish();
      end
    end
    drv_valid = 1'b0;
    model_accept(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst       = 1'b1;
    drv_valid = 1'b0;
    nsamp     = 0;
    exp_xp.delete();
    exp_st.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_xp.size() != 0 || exp_st.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_left_xp"}, exp_xp.size(), 0);
    chk({name, "_left_st"}, exp_st.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  int a_pop_first = -1, a_pop_last = -1;
  int b_pop_first = -1, b_pop_last = -1;

  task automatic check_out(input int inst, input logic [W:0] got);
    logic [W:0] req;
    string      nm;
    nm = (inst == 0) ? "out_xp" : "out_st";
    total++;
    if ((inst == 0 && exp_xp.size() == 0) || (inst == 1 && exp_st.size() == 0)) begin
      bad++;
      $display("FAIL %s unexpected got=%h required=none", nm, got);
    end else begin
      if (inst == 0) req = exp_xp.pop_front();
      else           req = exp_st.pop_front();
      if (got !== req) begin
        bad++;
        $display("FAIL %s got last=%0b data=%h required last=%0b data=%h",
                 nm, got[W], got[W-1:0], req[W], req[W-1:0]);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_ready && a_out_valid) begin
        check_out(0, {a_out_last, a_out_data});
        if (a_pop_first < 0) a_pop_first = cyc;
        a_pop_last = cyc;
      end
      if (!rst && out_ready && b_out_valid) begin
        check_out(1, {b_out_last, b_out_data});
        if (b_pop_first < 0) b_pop_first = cyc;
        b_pop_last = cyc;
      end
    end
  end

  // main sequence
  initial begin
    int t0, fa, fb;
    logic ready_seen, wr_seen, raddr_moved;
    rst         = 1'b1;
    drv_valid   = 1'b0;
    drv_data    = '0;
    ready_force = 1'b1;
    rnd_mode    = 1'b0;
    idle(3);
    rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready_xp", a_in_ready, 1);
    chk("rst_out_valid_xp", a_out_valid, 0);
    chk("rst_out_last_xp", a_out_last, 0);
    chk("rst_wr_xp", a_wr, 0);
    chk("rst_raddr_xp", a_raddr, 0);
    chk("rst_waddr_xp", a_waddr, 0);
    chk("rst_busy_xp", a_busy, 0);
    chk("rst_in_ready_st", b_in_ready, 1);
    chk("rst_out_valid_st", b_out_valid, 0);
    chk("rst_busy_st", b_busy, 0);
    @(posedge clk);
    #1;

    // single block 0..63 and first-output latency
    for (int i = 0; i < 64; i++) send(W'(i));
    t0 = last_acc_cyc;
    fa = -100;
    fb = -100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_out_valid && fa < 0) fa = cyc;
      if (b_out_valid && fb < 0) fb = cyc;
    end
    chk("latency_xp", fa - t0, 3);
    chk("latency_st", fb - t0, 3);
    @(posedge clk);
    #1;
    drain("single");
    idle(2);
    @(negedge clk);
    chk("idle_busy_xp", a_busy, 0);
    chk("idle_busy_st", b_busy, 0);
    @(posedge clk);
    #1;

    // three back-to-back blocks, outputs must be contiguous
    a_pop_first = -1;
    b_pop_first = -1;
    for (int i = 0; i < 192; i++) send(W'($urandom));
    drain("b2b");
    chk("contig_xp", a_pop_last - a_pop_first, 191);
    chk("contig_st", b_pop_last - b_pop_first, 191);

    // four blocks with random downstream ready and input gaps
    rnd_mode = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(W'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain("random");
    rnd_mode = 1'b0;

    // reset in the middle of a block discards the partial block
    for (int i = 0; i < 30; i++) send(W'($urandom));
    pulse_reset();
    @(negedge clk);
    chk("midrst_valid_xp", a_out_valid, 0);
    chk("midrst_busy_xp", a_busy, 0);
    chk("midrst_valid_st", b_out_valid, 0);
    chk("midrst_busy_st", b_busy, 0);
    chk("midrst_ready_xp", a_in_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) send(W'($urandom));
    drain("post_rst");

    // both banks occupied with downstream stalled
    ready_force = 1'b0;
    pulse_reset();
    for (int i = 0; i < 128; i++) send(W'($urandom));
    drv_valid   = 1'b1;
    drv_data    = W'($urandom);
    ready_seen  = 1'b0;
    wr_seen     = 1'b0;
    raddr_moved = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (a_in_ready || b_in_ready) ready_seen = 1'b1;
      if (a_wr || b_wr) wr_seen = 1'b1;
      if (a_raddr != 7'd8 || b_raddr != 7'd1) raddr_moved = 1'b1;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("stall_in_ready", ready_seen, 0);
    chk("stall_ram_wr", wr_seen, 0);
    chk("stall_raddr_xp", a_raddr, 8);
    chk("stall_raddr_st", b_raddr, 1);
    chk("stall_raddr_stable", raddr_moved, 0);
    chk("stall_busy_xp", a_busy, 1);
    @(posedge clk);
    #1;
    drv_valid   = 1'b0;
    ready_force = 1'b1;
    drain("stall");
    idle(2);
    @(negedge clk);
    chk("end_busy_xp", a_busy, 0);
    chk("end_busy_st", b_busy, 0);
    chk("end_valid_xp", a_out_valid, 0);

    report_and_finish();
  end

endmodule
